// File: rtl/vend_ctrl_multi_if.sv
// ---------------------------------------------------------------------------
// vend_ctrl_multi_if
// Bundles the coin/selection/restock requests and the vend/change/status
// responses of the multi-item vending controller.
//   master : drives coin, sel_valid, sel_item, cancel, restock, restock_item;
//            observes every status/response signal.
//   slave  : the controller side (mirror of master).
// Signals:
//   coin[2:0]          coin value this cycle (0 = none; 1, 2, 5 valid)
//   sel_valid/sel_item product selection strobe and index
//   cancel             refund request
//   restock/_item      reload one item's stock
//   dispense/_item     one-cycle vend pulse and the item being vended
//   change_valid/coin  one change coin per cycle (5, 2 or 1)
//   credit             current credit
//   busy               vending or paying out change
//   coin_reject        the coin seen last edge was refused
//   sel_error          the selection seen last edge was refused
//   sold_out           bit i set when item i has no stock left
// ---------------------------------------------------------------------------
interface vend_ctrl_multi_if #(
  parameter int NUM_ITEMS = 4,
  parameter int CREDIT_W  = 6,
  parameter int SEL_W     = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
);
  logic [2:0]           coin;
  logic                 sel_valid;
  logic [SEL_W-1:0]     sel_item;
  logic                 cancel;
  logic                 restock;
  logic [SEL_W-1:0]     restock_item;

  logic                 dispense;
  logic [SEL_W-1:0]     dispense_item;
  logic                 change_valid;
  logic [2:0]           change_coin;
  logic [CREDIT_W-1:0]  credit;
  logic                 busy;
  logic                 coin_reject;
  logic                 sel_error;
  logic [NUM_ITEMS-1:0] sold_out;

  modport master (
    output coin, sel_valid, sel_item, cancel, restock, restock_item,
    input  dispense, dispense_item, change_valid, change_coin, credit,
           busy, coin_reject, sel_error, sold_out
  );

  modport slave (
    input  coin, sel_valid, sel_item, cancel, restock, restock_item,
    output dispense, dispense_item, change_valid, change_coin, credit,
           busy, coin_reject, sel_error, sold_out
  );
endinterface

// File: rtl/vend_ctrl_multi.sv
// ---------------------------------------------------------------------------
// vend_ctrl_multi
// Multi-item vending controller. Accumulates 1/2/5 coins into a credit
// register, vends one of NUM_ITEMS products on a selection, keeps per-item
// stock, supports cancel/refund and pays change one greedy coin per cycle.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      vend_ctrl_multi_if.slave (requests in, vend/change/status out)
// ---------------------------------------------------------------------------
module vend_ctrl_multi #(
  parameter int                            NUM_ITEMS  = 4,
  parameter int                            CREDIT_W   = 6,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_LIST = {6'd12, 6'd10, 6'd9, 6'd7},
  parameter int                            STOCK_W    = 4,
  parameter int                            INIT_STOCK = 5,
  parameter int                            SEL_W      = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input logic              clk,
  input logic              reset_n,
  vend_ctrl_multi_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

  localparam int                CW1        = CREDIT_W + 1;
  localparam logic [CREDIT_W:0] CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};

  state_t                           state_reg, state_next;
  logic [CREDIT_W-1:0]              credit_reg, credit_next;
  logic                             dispense_reg, dispense_next;
  logic [SEL_W-1:0]                 dispense_item_reg, dispense_item_next;
  logic                             change_valid_reg, change_valid_next;
  logic [2:0]                       change_coin_reg, change_coin_next;
  logic                             coin_reject_next, coin_reject_reg;
  logic                             sel_error_next, sel_error_reg;
  logic                             take_item;
  logic [NUM_ITEMS-1:0][STOCK_W-1:0] stock;

  // Largest denomination that does not exceed the remaining credit.
  function automatic logic [2:0] greedy_coin(input logic [CREDIT_W-1:0] c);
    if (c >= CREDIT_W'(5)) return 3'd5;
    if (c >= CREDIT_W'(2)) return 3'd2;
    return 3'd1;
  endfunction

  // ---------------- coin acceptance ----------------
  logic                accept_window, coin_legal, coin_fits, coin_accept;
  logic [CREDIT_W:0]   coin_sum;
  logic [CREDIT_W-1:0] credit_with_coin;

  assign accept_window    = (state_reg == IDLE) || (state_reg == CREDIT);
  assign coin_legal       = (bus.coin == 3'd1) || (bus.coin == 3'd2) || (bus.coin == 3'd5);
  assign coin_sum         = {1'b0, credit_reg} + CW1'(bus.coin);
  assign coin_fits        = (coin_sum <= CREDIT_MAX);
  assign coin_accept      = accept_window && coin_legal && coin_fits;
  assign credit_with_coin = coin_accept ? coin_sum[CREDIT_W-1:0] : credit_reg;

  // ---------------- selection lookup ----------------
  // An out-of-range index matches no item, so it reads as "no stock" and
  // is refused through the same path as a sold-out item.
  logic [CREDIT_W-1:0] sel_price;
  logic                sel_in_stock, sel_ok;

  always_comb begin
    sel_price    = '0;
    sel_in_stock = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (int'(bus.sel_item) == i) begin
        sel_price    = PRICE_LIST[i*CREDIT_W +: CREDIT_W];
        sel_in_stock = (stock[i] != '0);
      end
    end
  end

  // Price is compared against credit before this cycle's coin.
  assign sel_ok = sel_in_stock && (credit_reg >= sel_price);

  // ---------------- FSM next state / registered outputs ----------------
  logic [CREDIT_W-1:0] remaining;

  always_comb begin
    state_next         = state_reg;
    credit_next        = credit_reg;
    dispense_next      = 1'b0;
    dispense_item_next = '0;
    change_valid_next  = 1'b0;
    change_coin_next   = 3'd0;
    sel_error_next     = 1'b0;
    take_item          = 1'b0;
    remaining          = '0;
    coin_reject_next   = (bus.coin != 3'd0) && !coin_accept;

    unique case (state_reg)
      IDLE: begin
        credit_next = credit_with_coin;
        if (coin_accept) state_next = CREDIT;
        if (bus.sel_valid) sel_error_next = 1'b1;
      end

      CREDIT: begin
        credit_next = credit_with_coin;
        if (bus.cancel) begin
          // Refund includes a coin accepted in the same cycle; credit is
          // never zero here, so there is always at least one coin.
          state_next        = CHANGE;
          change_valid_next = 1'b1;
          change_coin_next  = greedy_coin(credit_with_coin);
        end else if (bus.sel_valid) begin
          if (sel_ok) begin
            credit_next        = credit_with_coin - sel_price;
            state_next         = VEND;
            dispense_next      = 1'b1;
            dispense_item_next = bus.sel_item;
            take_item          = 1'b1;
          end else begin
            sel_error_next = 1'b1;
          end
        end
      end

      VEND: begin
        if (credit_reg != '0) begin
          state_next        = CHANGE;
          change_valid_next = 1'b1;
          change_coin_next  = greedy_coin(credit_reg);
        end else begin
          state_next = IDLE;
        end
      end

      CHANGE: begin
        // credit still includes the coin on the output this cycle; it is
        // removed at the edge that ends the cycle.
        remaining   = credit_reg - CREDIT_W'(greedy_coin(credit_reg));
        credit_next = remaining;
        if (remaining == '0) begin
          state_next = IDLE;
        end else begin
          change_valid_next = 1'b1;
          change_coin_next  = greedy_coin(remaining);
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg         <= IDLE;
      credit_reg        <= '0;
      dispense_reg      <= 1'b0;
      dispense_item_reg <= '0;
      change_valid_reg  <= 1'b0;
      change_coin_reg   <= 3'd0;
      coin_reject_reg   <= 1'b0;
      sel_error_reg     <= 1'b0;
    end else begin
      state_reg         <= state_next;
      credit_reg        <= credit_next;
      dispense_reg      <= dispense_next;
      dispense_item_reg <= dispense_item_next;
      change_valid_reg  <= change_valid_next;
      change_coin_reg   <= change_coin_next;
      coin_reject_reg   <= coin_reject_next;
      sel_error_reg     <= sel_error_next;
    end
  end

  // ---------------- per-item stock ----------------
  // Stock is taken at the accepting edge so sold_out is already current
  // during the dispense cycle. Restock of the same item wins.
  generate
    for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_stock
      logic [STOCK_W-1:0] stock_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          stock_reg <= STOCK_W'(INIT_STOCK);
        end else if (bus.restock && (int'(bus.restock_item) == gi)) begin
          stock_reg <= STOCK_W'(INIT_STOCK);
        end else if (take_item && (int'(bus.sel_item) == gi)) begin
          stock_reg <= stock_reg - STOCK_W'(1);
        end
      end

      assign stock[gi]        = stock_reg;
      assign bus.sold_out[gi] = (stock_reg == '0);
    end
  endgenerate

  assign bus.dispense      = dispense_reg;
  assign bus.dispense_item = dispense_item_reg;
  assign bus.change_valid  = change_valid_reg;
  assign bus.change_coin   = change_coin_reg;
  assign bus.credit        = credit_reg;
  assign bus.busy          = (state_reg == VEND) || (state_reg == CHANGE);
  assign bus.coin_reject   = coin_reject_reg;
  assign bus.sel_error     = sel_error_reg;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// ---------------------------------------------------------------------------
// tb_vend_ctrl_multi
// Directed scenarios with literal expectations, then randomized traffic.
// A transaction-level model (credit as a number, change as a queue of
// coins, stock as an array) predicts every output; one negedge process
// compares the DUT against it each cycle.
// ---------------------------------------------------------------------------
module tb_vend_ctrl_multi;
  localparam int NUM_ITEMS  = 4;
  localparam int CREDIT_W   = 6;
  localparam int SEL_W      = 2;
  localparam int INIT_STOCK = 5;
  localparam int MAX_CREDIT = 63;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  vend_ctrl_multi_if #(.NUM_ITEMS(NUM_ITEMS), .CREDIT_W(CREDIT_W), .SEL_W(SEL_W)) bus ();

  vend_ctrl_multi #(
    .NUM_ITEMS (NUM_ITEMS),
    .CREDIT_W  (CREDIT_W),
    .PRICE_LIST({6'd12, 6'd10, 6'd9, 6'd7}),
    .STOCK_W   (4),
    .INIT_STOCK(INIT_STOCK),
    .SEL_W     (SEL_W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_credit;
  int m_stock[NUM_ITEMS];
  bit m_vend;
  int m_item;
  int m_q[$];      // change coins still to appear; front = coin shown now
  bit m_rej;
  bit m_selerr;

  function automatic int price_of(int i);
    case (i)
      0: return 7;
      1: return 9;
      2: return 10;
      default: return 12;
    endcase
  endfunction

  task automatic model_reset();
    m_credit = 0;
    foreach (m_stock[i]) m_stock[i] = INIT_STOCK;
    m_vend = 0;
    m_item = 0;
    m_q.delete();
    m_rej = 0;
    m_selerr = 0;
  endtask

  // Pay out c rupees: as many 5s as fit, then 2s, then at most one 1.
  task automatic refund_all(int c);
    m_q.delete();
    repeat (c / 5) m_q.push_back(5);
    repeat ((c % 5) / 2) m_q.push_back(2);
    if (((c % 5) % 2) != 0) m_q.push_back(1);
    m_credit = c;
  endtask

  task automatic model_step(int coin, bit sv, int si, bit cn, bit rs, int ri);
    bit was_vend;
    int acc;
    was_vend = m_vend;
    acc = 0;
    m_rej = 0;
    m_selerr = 0;
    m_vend = 0;
    m_item = 0;
    if (was_vend) begin
      m_rej = (coin != 0);
      if (m_credit > 0) refund_all(m_credit);
    end else if (m_q.size() > 0) begin
      m_rej = (coin != 0);
      void'(m_q.pop_front());
      m_credit = 0;
      foreach (m_q[i]) m_credit += m_q[i];
    end else begin
      if (coin != 0) begin
        if ((coin == 1 || coin == 2 || coin == 5) && (m_credit + coin <= MAX_CREDIT)) acc = coin;
        else m_rej = 1;
      end
      if (m_credit == 0) begin
        m_selerr = sv;
        m_credit = acc;
      end else if (cn) begin
        refund_all(m_credit + acc);
      end else if (sv && si < NUM_ITEMS && m_stock[si] > 0 && m_credit >= price_of(si)) begin
        m_credit = m_credit + acc - price_of(si);
        m_vend = 1;
        m_item = si;
        m_stock[si] = m_stock[si] - 1;
      end else begin
        m_selerr = sv;
        m_credit = m_credit + acc;
      end
    end
    if (rs && ri < NUM_ITEMS) m_stock[ri] = INIT_STOCK;
  endtask

  // ---------------- checking ----------------
  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      int so;
      so = 0;
      for (int i = 0; i < NUM_ITEMS; i++) if (m_stock[i] == 0) so |= (1 << i);
      chk("dispense", int'(bus.dispense), int'(m_vend));
      chk("dispense_item", int'(bus.dispense_item), m_vend ? m_item : 0);
      chk("change_valid", int'(bus.change_valid), (m_q.size() > 0) ? 1 : 0);
      chk("change_coin", int'(bus.change_coin), (m_q.size() > 0) ? m_q[0] : 0);
      chk("credit", int'(bus.credit), m_credit);
      chk("busy", int'(bus.busy), (m_vend || m_q.size() > 0) ? 1 : 0);
      chk("coin_reject", int'(bus.coin_reject), int'(m_rej));
      chk("sel_error", int'(bus.sel_error), int'(m_selerr));
      chk("sold_out", int'(bus.sold_out), so);
    end
  end

  // ---------------- stimulus ----------------
  // Inputs change 1 time unit after a rising edge and are held through the
  // next one; the model advances just after that edge.
  task automatic step(int coin, bit sv, int si, bit cn, bit rs, int ri);
    bus.coin = 3'(coin);
    bus.sel_valid = sv;
    bus.sel_item = SEL_W'(si);
    bus.cancel = cn;
    bus.restock = rs;
    bus.restock_item = SEL_W'(ri);
    @(posedge clk);
    #1;
    if (reset_n) model_step(coin, sv, si, cn, rs, ri);
    else model_reset();
  endtask

  task automatic put(int c);     step(c, 0, 0, 0, 0, 0); endtask
  task automatic sel(int i);     step(0, 1, i, 0, 0, 0); endtask
  task automatic nop();          step(0, 0, 0, 0, 0, 0); endtask
  task automatic cancel_req();   step(0, 0, 0, 1, 0, 0); endtask

  task automatic async_reset();
    #1 reset_n = 1'b0;
    #1;
    chk("arst_credit", int'(bus.credit), 0);
    chk("arst_change_valid", int'(bus.change_valid), 0);
    chk("arst_busy", int'(bus.busy), 0);
    nop();
    reset_n = 1'b1;
  endtask

  initial begin
    bus.coin = '0;
    bus.sel_valid = 1'b0;
    bus.sel_item = '0;
    bus.cancel = 1'b0;
    bus.restock = 1'b0;
    bus.restock_item = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("reset_credit", int'(bus.credit), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_sold_out", int'(bus.sold_out), 0);

    // Exact pay
    put(2); put(5);
    chk("exact_credit", int'(bus.credit), 7);
    sel(0);
    chk("exact_dispense", int'(bus.dispense), 1);
    chk("exact_item", int'(bus.dispense_item), 0);
    chk("exact_credit_after", int'(bus.credit), 0);
    nop();
    chk("exact_no_change", int'(bus.change_valid), 0);
    chk("exact_dispense_drop", int'(bus.dispense), 0);

    // Overpay: 10 for a 7 -> change 2 then 1
    put(5); put(5); sel(0);
    chk("over_dispense", int'(bus.dispense), 1);
    nop();
    chk("over_change1", int'(bus.change_coin), 2);
    nop();
    chk("over_change2", int'(bus.change_coin), 1);
    nop();
    chk("over_done_valid", int'(bus.change_valid), 0);
    chk("over_done_credit", int'(bus.credit), 0);

    // Refund 8 -> 5, 2, 1
    put(5); put(2); put(1);
    chk("refund_credit", int'(bus.credit), 8);
    cancel_req();
    chk("refund_c1", int'(bus.change_coin), 5);
    chk("refund_no_disp", int'(bus.dispense), 0);
    nop();
    chk("refund_c2", int'(bus.change_coin), 2);
    nop();
    chk("refund_c3", int'(bus.change_coin), 1);
    nop();

    // Cancel beats a same-cycle selection
    put(2);
    step(0, 1, 0, 1, 0, 0);
    chk("cansel_coin", int'(bus.change_coin), 2);
    chk("cansel_no_selerr", int'(bus.sel_error), 0);
    nop();

    // Too little credit for item1
    put(5); sel(1);
    chk("poor_selerr", int'(bus.sel_error), 1);
    chk("poor_credit", int'(bus.credit), 5);
    cancel_req(); nop();

    // Invalid coin code
    put(3);
    chk("bad_coin_reject", int'(bus.coin_reject), 1);
    chk("bad_coin_credit", int'(bus.credit), 0);

    // Coin while paying change
    put(5); put(2); cancel_req();
    put(1);
    chk("change_coin_reject", int'(bus.coin_reject), 1);
    nop();

    // Reset in the middle of a refund
    put(5); put(5); cancel_req();
    async_reset();

    // Stock exhaustion and restock
    for (int k = 0; k < 5; k++) begin
      put(5); put(2); sel(0);
      if (k == 4) chk("soldout_set", int'(bus.sold_out[0]), 1);
      nop();
    end
    put(5); put(2); sel(0);
    chk("soldout_selerr", int'(bus.sel_error), 1);
    step(0, 0, 0, 0, 1, 0);
    chk("restock_clear", int'(bus.sold_out[0]), 0);
    sel(0);
    chk("restock_vend", int'(bus.dispense), 1);
    nop();

    // Credit overflow
    repeat (12) put(5);
    chk("ovf_60", int'(bus.credit), 60);
    put(5);
    chk("ovf_rej5", int'(bus.coin_reject), 1);
    chk("ovf_keep60", int'(bus.credit), 60);
    put(2);
    chk("ovf_62", int'(bus.credit), 62);
    put(2);
    chk("ovf_rej2", int'(bus.coin_reject), 1);
    put(1);
    chk("ovf_63", int'(bus.credit), 63);
    cancel_req();
    repeat (14) nop();
    chk("ovf_drained", int'(bus.busy), 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r, c;
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 2, 3: c = 0;
        4: c = 1;
        5: c = 2;
        6, 7: c = 5;
        default: c = int'($urandom_range(0, 7));
      endcase
      step(c, ($urandom_range(0, 4) == 0), int'($urandom_range(0, 3)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 39) == 0),
           int'($urandom_range(0, 3)));
      if (n == 1500) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vend_ctrl_multi.md
# vend_ctrl_multi

Parametrised multi-item successor to the single-price vending FSM. Accepts 1/2/5-rupee coins into a credit register and vends one of NUM_ITEMS products on an explicit selection. Tracks per-item stock, supports cancel/refund, and returns change one coin per cycle using greedy 5/2/1 denominations. It sits between the coin acceptor and the dispenser and change-hopper drivers.

## Interface
- NUM_ITEMS, 4: number of products; SEL_W = max(1, $clog2(NUM_ITEMS)).
- CREDIT_W, 6: credit register width; the maximum credit is 2^CREDIT_W-1.
- PRICE_LIST, {6'd12,6'd10,6'd9,6'd7}: packed NUM_ITEMS*CREDIT_W prices; item i is slice i, so item0 = 7 and item1 = 9.
- STOCK_W, 4: per-item stock counter width.
- INIT_STOCK, 5: stock loaded at reset and by restock.
- clk  in  1  single clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- coin  in  3  coin value this cycle: 0 = none; 1, 2 and 5 are valid; any other code is invalid.
- sel_valid  in  1  product selection strobe.
- sel_item  in  SEL_W  selected product index.
- cancel  in  1  refund request.
- restock  in  1  restock strobe.
- restock_item  in  SEL_W  item to restock.
- dispense  out  1  one-cycle vend pulse.
- dispense_item  out  SEL_W  item being vended; valid while dispense=1.
- change_valid  out  1  a change coin is output this cycle.
- change_coin  out  3  value of the change coin (5, 2 or 1); 0 when change_valid=0.
- credit  out  CREDIT_W  current credit.
- busy  out  1  high in VEND and CHANGE.
- coin_reject  out  1  one-cycle pulse: the coin this cycle was not accepted.
- sel_error  out  1  one-cycle pulse: the selection this cycle was refused.
- sold_out  out  NUM_ITEMS  bit i = (stock[i] == 0).

## Operation
- FSM states: IDLE (credit = 0), CREDIT, VEND, CHANGE.
- Reset (reset_n=0, asynchronous) forces:
  - state IDLE, credit 0, every stock counter = INIT_STOCK;
  - dispense, dispense_item, change_valid, change_coin, coin_reject, sel_error and busy all 0.
- Coin handling in IDLE or CREDIT:
  - coin in {1,2,5} with credit+coin ≤ 2^CREDIT_W-1 → credit += coin; IDLE moves to CREDIT.
  - invalid code, or a coin that would overflow → coin_reject pulse; credit unchanged.
- Coin handling in VEND or CHANGE: any nonzero coin → coin_reject.
- Selection, evaluated only in CREDIT, uses the credit value *before* this cycle's coin:
  - sel_ok = (stock[sel_item] ≠ 0) && (credit ≥ price[sel_item]) && (sel_item < NUM_ITEMS).
  - sel_ok → credit_next = credit + accepted_coin - price; latch the item; go to VEND.
  - otherwise → sel_error pulse; stay in CREDIT; the coin is still accepted.
  - sel_valid in IDLE → sel_error.
- Cancel in CREDIT → go to CHANGE; full credit is refunded, including any coin accepted the same cycle. Cancel beats sel_valid in the same cycle; no sel_error is raised. Cancel in IDLE is ignored.
- VEND (exactly 1 cycle):
  - dispense=1 with dispense_item = latched item; that item's stock decrements.
  - next state: CHANGE if credit > 0, else IDLE.
- CHANGE, each cycle:
  - change_valid=1 and change_coin = 5 if credit ≥ 5, else 2 if credit ≥ 2, else 1; credit -= change_coin.
  - when credit reaches 0, return to IDLE.
  - sel_valid and cancel are ignored, with no sel_error.
- Restock is honoured in any state: stock[restock_item] ← INIT_STOCK. It takes priority over a same-cycle decrement of the same item. Out-of-range restock_item is ignored.
- Stock never decrements below 0; the sel_ok gate guarantees this.

## Timing
- All outputs are registered. Pulses (coin_reject, sel_error) appear in the cycle after the offending input edge.
- Coin sampled at edge N → credit updated after edge N.
- Vend sequence for a selection accepted at edge N:
  - dispense=1 during cycle N+1.
  - first change coin during cycle N+2.
  - change of C rupees takes ceil-greedy(C) consecutive cycles, then IDLE.
- Cancel at edge N → first refund coin during cycle N+1.
- sold_out reflects stock after the edge; restock clears it one cycle after the strobe.
- reset_n assertion mid-VEND/CHANGE clears all outputs immediately (asynchronously); pending change is discarded.

## Test plan
- Exact pay: coins 2, 5 then sel item0 → credit 7; dispense=1 for 1 cycle with dispense_item=0; no change; credit 0; stock0 = 4.
- Overpay: 5, 5, sel item0 → dispense, then change_coin 2, then 1 on consecutive cycles; IDLE; credit 0.
- Refund: 5, 2, 1, cancel → change 5, 2, 1 over 3 cycles; no dispense. Cancel+sel same cycle → refund only, no sel_error.
- Refusals:
  - credit 5, sel item1 (price 9) → sel_error; credit stays 5.
  - coin 3'b011 → coin_reject.
  - coin during CHANGE → coin_reject.
  - reset_n low mid-CHANGE → credit 0, change_valid 0 immediately.
- Stock: five item0 purchases → sold_out[0]=1; sixth sel item0 → sel_error; restock item0 → sold_out[0]=0 and stock 5.
- Overflow: credit 60 (twelve 5s); coin 5 → coin_reject with credit 60; coin 2 → credit 62; coin 2 → reject; coin 1 → 63.
